// File: rtl/debug_cmd_sequencer_if.sv
// Bundle of UART byte strobes, pipeline control, imem write port and snapshot input.
// The sequencer uses the slave modport; whatever drives the UART side uses the master modport.
interface debug_cmd_sequencer_if #(
    parameter int SNAP_W  = 1376,
    parameter int INSTR_W = 32,
    parameter int ADDR_W  = 8
);
    logic               rx_done_tick;
    logic [7:0]         rx_data;
    logic               tx_done_tick;
    logic               pipe_halt;
    logic [SNAP_W-1:0]  snapshot;
    logic               pipe_en;
    logic               pipe_rst;
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               tx_start;
    logic [7:0]         tx_data;
    logic               busy;

    modport slave (
        input  rx_done_tick, rx_data, tx_done_tick, pipe_halt, snapshot,
        output pipe_en, pipe_rst, imem_we, imem_addr, imem_data, tx_start, tx_data, busy
    );

    modport master (
        output rx_done_tick, rx_data, tx_done_tick, pipe_halt, snapshot,
        input  pipe_en, pipe_rst, imem_we, imem_addr, imem_data, tx_start, tx_data, busy
    );
endinterface

// File: rtl/debug_cmd_sequencer.sv
// UART command sequencer: loads imem, runs/steps/resets the pipeline, dumps the snapshot bytewise.
// All outputs registered (1 cycle after the deciding tick); each dump byte waits for tx_done_tick.
module debug_cmd_sequencer #(
    parameter int SNAP_W  = 1376,
    parameter int INSTR_W = 32,
    parameter int ADDR_W  = 8,
    parameter int RUN_MAX = 1024
) (
    input  logic                   top_clk,
    input  logic                   reset,
    debug_cmd_sequencer_if.slave   bus
);
    localparam int NBYTES = SNAP_W / 8;
    localparam int BYTE_W = $clog2(NBYTES);
    localparam int RUN_W  = $clog2(RUN_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, LD_CNT, LD_DATA, RUN, STEP, PRST, DUMP_SEND, DUMP_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [7:0]         widx_q, widx_d;
    logic [1:0]         bidx_q, bidx_d;
    logic [INSTR_W-1:0] word_q, word_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [BYTE_W-1:0]  k_q, k_d;
    logic [SNAP_W-1:0]  snap_q, snap_d;

    logic               pipe_en_q, pipe_en_d;
    logic               pipe_rst_q, pipe_rst_d;
    logic               imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
    logic [INSTR_W-1:0] imem_data_q, imem_data_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        widx_d      = widx_q;
        bidx_d      = bidx_q;
        word_d      = word_q;
        run_d       = run_q;
        k_d         = k_q;
        snap_d      = snap_q;
        imem_we_d   = 1'b0;
        imem_addr_d = imem_addr_q;
        imem_data_d = imem_data_q;

        case (state_q)
            IDLE: begin
                if (bus.rx_done_tick) begin
                    case (bus.rx_data)
                        8'h4C: state_d = LD_CNT;
                        8'h52: begin
                            state_d = RUN;
                            run_d   = '0;
                        end
                        8'h53: state_d = STEP;
                        8'h44: state_d = DUMP_SEND;
                        8'h58: state_d = PRST;
                        default: state_d = IDLE;
                    endcase
                end
            end
            LD_CNT: begin
                if (bus.rx_done_tick) begin
                    if (bus.rx_data == 8'h00) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = bus.rx_data;
                        widx_d  = '0;
                        bidx_d  = '0;
                        state_d = LD_DATA;
                    end
                end
            end
            LD_DATA: begin
                if (bus.rx_done_tick) begin
                    // little-endian: each new byte enters at the top and shifts down
                    word_d = {bus.rx_data, word_q[INSTR_W-1:8]};
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        imem_we_d   = 1'b1;
                        imem_addr_d = ADDR_W'(widx_q);
                        imem_data_d = word_d;
                        widx_d      = widx_q + 8'd1;
                        if (widx_q == cnt_q - 8'd1) begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            RUN: begin
                run_d = run_q + 1'b1;
                if (bus.pipe_halt || (bus.rx_done_tick && bus.rx_data == 8'h48) ||
                    run_q == RUN_W'(RUN_MAX - 1)) begin
                    state_d = DUMP_SEND;
                end
            end
            STEP:      state_d = DUMP_SEND;
            PRST:      state_d = IDLE;
            DUMP_SEND: state_d = DUMP_WAIT;
            DUMP_WAIT: begin
                if (bus.tx_done_tick) begin
                    if (k_q == BYTE_W'(NBYTES - 1)) begin
                        state_d = IDLE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        snap_d  = snap_q >> 8;
                        state_d = DUMP_SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Capture the snapshot on the edge that starts a dump, so byte 0 leaves with it.
        if (state_d == DUMP_SEND && state_q != DUMP_WAIT) begin
            snap_d = bus.snapshot;
            k_d    = '0;
        end

        pipe_en_d  = (state_d == RUN) || (state_d == STEP);
        pipe_rst_d = (state_d == PRST);
        tx_start_d = (state_d == DUMP_SEND);
        tx_data_d  = snap_d[7:0];
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge top_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pipe_en_q   <= 1'b0;
            pipe_rst_q  <= 1'b1;
            imem_we_q   <= 1'b0;
            imem_addr_q <= '0;
            imem_data_q <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pipe_en_q   <= pipe_en_d;
            pipe_rst_q  <= pipe_rst_d;
            imem_we_q   <= imem_we_d;
            imem_addr_q <= imem_addr_d;
            imem_data_q <= imem_data_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
        end
    end

    always_ff @(posedge top_clk) begin
        cnt_q  <= cnt_d;
        widx_q <= widx_d;
        bidx_q <= bidx_d;
        word_q <= word_d;
        run_q  <= run_d;
        k_q    <= k_d;
        snap_q <= snap_d;
    end

    assign bus.pipe_en   = pipe_en_q;
    assign bus.pipe_rst  = pipe_rst_q;
    assign bus.imem_we   = imem_we_q;
    assign bus.imem_addr = imem_addr_q;
    assign bus.imem_data = imem_data_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_debug_cmd_sequencer.sv
// Scoreboarded bench for debug_cmd_sequencer: imem writes and dump bytes are queued at stimulus
// time and popped by a negedge monitor that also acknowledges every transmitted byte.
module tb_debug_cmd_sequencer;
    localparam int SNAP_W = 1376;
    localparam int NBYTES = SNAP_W / 8;

    logic top_clk = 1'b0;
    logic reset;
    always #5 top_clk = ~top_clk;

    debug_cmd_sequencer_if #(.SNAP_W(SNAP_W), .INSTR_W(32), .ADDR_W(8)) dif ();

    debug_cmd_sequencer #(.SNAP_W(SNAP_W), .INSTR_W(32), .ADDR_W(8), .RUN_MAX(1024)) dut (
        .top_clk (top_clk),
        .reset   (reset),
        .bus     (dif.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    int en_cnt = 0, rst_cnt = 0, we_cnt = 0, tx_cnt = 0, ovl_cnt = 0;
    int tx_mark = 0, en_mark = 0, ack_cnt = 0;
    logic ack_en = 1'b1;
    logic halt_arm = 1'b0;
    logic [7:0] first_byte = 8'h00;
    logic [SNAP_W-1:0] snap_base = '0;
    logic [63:0] exp_we[$];
    logic [7:0]  exp_tx[$];

    // Snapshot changes once the dump has started, so a non-latching design sends wrong bytes.
    assign dif.snapshot  = (tx_cnt > tx_mark) ? ~snap_base : snap_base;
    assign dif.pipe_halt = halt_arm && ((en_cnt - en_mark) >= 10);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge top_clk);
        dif.rx_data      = b;
        dif.rx_done_tick = 1'b1;
        @(negedge top_clk);
        dif.rx_done_tick = 1'b0;
        repeat (2) @(negedge top_clk);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (dif.busy && n < budget) begin
            @(negedge top_clk);
            n++;
        end
        chk(tag, {63'd0, dif.busy}, 64'd0);
    endtask

    task automatic set_snap(input logic [7:0] pc);
        for (int i = 0; i < SNAP_W / 32; i++) snap_base[32*i +: 32] = $urandom;
        snap_base[7:0] = pc;
    endtask

    task automatic push_dump();
        tx_mark = tx_cnt;
        for (int k = 0; k < NBYTES; k++) exp_tx.push_back(snap_base[8*k +: 8]);
    endtask

    // Monitor and tx_done responder
    initial begin
        dif.tx_done_tick = 1'b0;
        forever begin
            @(negedge top_clk);
            if (dif.tx_done_tick) dif.tx_done_tick = 1'b0;
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) dif.tx_done_tick = 1'b1;
            end
            if (dif.pipe_en) en_cnt++;
            if (dif.pipe_rst) rst_cnt++;
            if (dif.pipe_en && dif.pipe_rst) ovl_cnt++;
            if (dif.imem_we) begin
                we_cnt++;
                if (exp_we.size() == 0) chk("imem_unexpected", 64'd1, 64'd0);
                else chk("imem_word", {24'd0, dif.imem_addr, dif.imem_data}, exp_we.pop_front());
            end
            if (dif.tx_start) begin
                if (tx_cnt == tx_mark) first_byte = dif.tx_data;
                tx_cnt++;
                if (exp_tx.size() == 0) chk("tx_unexpected", 64'd1, 64'd0);
                else chk("tx_byte", {56'd0, dif.tx_data}, {56'd0, exp_tx.pop_front()});
                if (ack_en) ack_cnt = 4;
            end
        end
    end

    logic [7:0] ld2 [10] = '{8'h4C, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [7:0] ld1 [6]  = '{8'h4C, 8'h01, 8'h4C, 8'h11, 8'h22, 8'h33};

    initial begin
        int w0, e0, t0, r0, n;
        reset            = 1'b1;
        dif.rx_done_tick = 1'b0;
        dif.rx_data      = 8'h00;
        repeat (4) @(negedge top_clk);
        chk("rst_pipe_rst", {63'd0, dif.pipe_rst}, 64'd1);
        chk("rst_pipe_en", {63'd0, dif.pipe_en}, 64'd0);
        chk("rst_busy", {63'd0, dif.busy}, 64'd0);
        chk("rst_tx_start", {63'd0, dif.tx_start}, 64'd0);
        chk("rst_imem_we", {63'd0, dif.imem_we}, 64'd0);
        chk("rst_imem_bus", {24'd0, dif.imem_addr, dif.imem_data}, 64'd0);
        reset = 1'b0;
        @(negedge top_clk);
        chk("release_pipe_rst", {63'd0, dif.pipe_rst}, 64'd0);

        // Two-word program load
        w0 = we_cnt;
        exp_we.push_back({24'd0, 8'd0, 32'h12345678});
        exp_we.push_back({24'd0, 8'd1, 32'hDEADBEEF});
        for (int i = 0; i < 10; i++) send_byte(ld2[i]);
        wait_idle("ld2_idle", 50);
        chk("ld2_writes", 64'(we_cnt - w0), 64'd2);

        // Single step then dump
        set_snap(8'h05);
        push_dump();
        e0 = en_cnt; t0 = tx_cnt;
        send_byte(8'h53);
        wait_idle("step_idle", 3000);
        chk("step_en_cycles", 64'(en_cnt - e0), 64'd1);
        chk("step_tx_count", 64'(tx_cnt - t0), 64'(NBYTES));
        chk("step_first_byte", {56'd0, first_byte}, 64'h05);
        chk("step_q_empty", 64'(exp_tx.size()), 64'd0);

        // Run stopped by pipe_halt after 10 enable cycles
        set_snap(8'h21);
        push_dump();
        en_mark = en_cnt; t0 = tx_cnt;
        halt_arm = 1'b1;
        send_byte(8'h52);
        wait_idle("halt_idle", 3000);
        halt_arm = 1'b0;
        chk("halt_en_cycles", 64'(en_cnt - en_mark), 64'd10);
        chk("halt_tx_count", 64'(tx_cnt - t0), 64'(NBYTES));

        // Run to watchdog; bytes during RUN are dropped
        set_snap(8'h3C);
        push_dump();
        e0 = en_cnt; t0 = tx_cnt; w0 = we_cnt;
        send_byte(8'h52);
        send_byte(8'h4C);
        send_byte(8'h53);
        wait_idle("wdog_idle", 5000);
        chk("wdog_en_cycles", 64'(en_cnt - e0), 64'd1024);
        chk("wdog_tx_count", 64'(tx_cnt - t0), 64'(NBYTES));
        chk("wdog_no_writes", 64'(we_cnt - w0), 64'd0);

        // Run stopped by 'H'
        set_snap(8'h77);
        push_dump();
        e0 = en_cnt; t0 = tx_cnt;
        send_byte(8'h52);
        repeat (20) @(negedge top_clk);
        send_byte(8'h48);
        wait_idle("hstop_idle", 3000);
        chk("hstop_en_range", {63'd0, (en_cnt - e0) > 10 && (en_cnt - e0) < 64}, 64'd1);
        chk("hstop_tx_count", 64'(tx_cnt - t0), 64'(NBYTES));

        // Command code as load data, then a stray byte in IDLE
        w0 = we_cnt;
        exp_we.push_back({24'd0, 8'd0, 32'h3322114C});
        for (int i = 0; i < 6; i++) send_byte(ld1[i]);
        wait_idle("ld1_idle", 50);
        chk("ld1_writes", 64'(we_cnt - w0), 64'd1);
        send_byte(8'h00);
        chk("stray_busy", {63'd0, dif.busy}, 64'd0);

        // Zero-length load
        w0 = we_cnt;
        send_byte(8'h4C);
        send_byte(8'h00);
        chk("ld0_busy", {63'd0, dif.busy}, 64'd0);
        chk("ld0_writes", 64'(we_cnt - w0), 64'd0);

        // Pipeline reset pulse
        r0 = rst_cnt; e0 = en_cnt;
        send_byte(8'h58);
        wait_idle("prst_idle", 50);
        chk("prst_cycles", 64'(rst_cnt - r0), 64'd1);
        chk("prst_no_en", 64'(en_cnt - e0), 64'd0);

        // Reset while waiting on byte 50
        set_snap(8'h99);
        push_dump();
        send_byte(8'h44);
        n = 0;
        while ((tx_cnt - tx_mark) < 50 && n < 3000) begin
            @(negedge top_clk);
            n++;
        end
        chk("abort_reached", 64'(tx_cnt - tx_mark), 64'd50);
        @(negedge top_clk);
        reset = 1'b1;
        t0 = tx_cnt;
        repeat (5) @(negedge top_clk);
        chk("abort_pipe_rst", {63'd0, dif.pipe_rst}, 64'd1);
        chk("abort_busy_rst", {63'd0, dif.busy}, 64'd0);
        reset = 1'b0;
        repeat (200) @(negedge top_clk);
        chk("abort_no_tx", 64'(tx_cnt - t0), 64'd0);
        chk("abort_busy", {63'd0, dif.busy}, 64'd0);
        chk("abort_pipe_rst_low", {63'd0, dif.pipe_rst}, 64'd0);
        exp_tx.delete();

        chk("en_rst_overlap", 64'(ovl_cnt), 64'd0);
        chk("imem_q_empty", 64'(exp_we.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
